// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the N-channel registered arbitrating multiplexer.
// Selection mode codes and the round-robin pointer advance.
package mux_arb_pkg;

  localparam int unsigned MODE_SEL = 0;
  localparam int unsigned MODE_RR  = 1;

  // Channel after g, wrapping at num_ch (valid for any num_ch, not only powers of two).
  function automatic int unsigned next_ptr(int unsigned g, int unsigned num_ch);
    return (g == num_ch - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// Handshake bundle between NUM_CH producers, the arbitrating mux and one consumer.
// slave is the mux side; master is the producer/consumer side.
interface mux_arb_n_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
);

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_ready;

  modport master (
    output in_valid,
    output in_data,
    output sel,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ch
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  sel,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ch
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, modulo NUM_CH.
// Purely combinational; the owner holds the pointer.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic              grant_valid_o,
  output logic [SEL_W-1:0]  grant_idx_o
);

  always_comb begin
    int unsigned k;
    k             = 0;
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      // Wrap by subtraction so non-power-of-two channel counts need no modulo.
      k = 32'(ptr_i) + i;
      if (k >= NUM_CH) begin
        k = k - NUM_CH;
      end
      if (!grant_valid_o && req_i[SEL_W'(k)]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel registered multiplexer with valid/ready on every port, selecting either by an
// external sel input (MODE_SEL) or by round-robin arbitration (MODE_RR).
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_CH),
  parameter int unsigned MODE   = MODE_SEL
) (
  input logic         clk,
  input logic         rst_n,
  mux_arb_n_if.slave  bus_io
);

  logic                 load_en;
  logic                 grant_valid;
  logic [SEL_W-1:0]     grant_idx;
  logic [NUM_CH-1:0]    in_ready;
  logic                 xfer;
  logic [WIDTH-1:0]     grant_data;

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0]     out_ch_q, out_ch_d;
  logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;

  // The register can take a new word when empty or when it drains this cycle.
  assign load_en = !out_valid_q || bus_io.out_ready;

  if (MODE == MODE_RR) begin : g_rr
    rr_arbiter #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
    ) u_rr_arbiter (
      .req_i         (bus_io.in_valid),
      .ptr_i         (rr_ptr_q),
      .grant_valid_o (grant_valid),
      .grant_idx_o   (grant_idx)
    );
  end else begin : g_sel
    localparam int unsigned PadW = 1 << SEL_W;
    logic [PadW-1:0] valid_pad;

    // Zero-padded so sel values beyond NUM_CH index a defined 0.
    assign valid_pad   = PadW'(bus_io.in_valid);
    assign grant_idx   = bus_io.sel;
    assign grant_valid = (32'(bus_io.sel) < NUM_CH) && valid_pad[bus_io.sel];
  end

  always_comb begin
    in_ready = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      in_ready[k] = rst_n && load_en && grant_valid && (32'(grant_idx) == k);
    end
  end

  // Grant already implies in_valid of the granted channel.
  assign xfer = |in_ready;

  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (in_ready[k]) begin
        grant_data = bus_io.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_ch_d    = grant_idx;
      if (MODE == MODE_RR) begin
        rr_ptr_d = SEL_W'(next_ptr(32'(grant_idx), NUM_CH));
      end
    end else if (bus_io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Self-checking bench: three instances (SEL/4ch, RR/4ch, RR/3ch) against a cycle model
// derived from the channel-selection rules, plus table vectors and corner sequences.
module tb_mux_arb_n;
  import mux_arb_pkg::*;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0]  tv   [ND];
  logic [31:0] td   [ND][4];
  logic [1:0]  tsel [ND];
  logic        tor  [ND];

  logic [3:0]  ar   [ND];
  logic        aov  [ND];
  logic [31:0] aod  [ND];
  logic [1:0]  aoc  [ND];

  logic        m_ov  [ND];
  logic [31:0] m_od  [ND];
  int          m_oc  [ND];
  int          m_ptr [ND];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_arb_n_if #(.WIDTH(32), .NUM_CH(4)) if_sel ();
  mux_arb_n_if #(.WIDTH(32), .NUM_CH(4)) if_rr4 ();
  mux_arb_n_if #(.WIDTH(32), .NUM_CH(3)) if_rr3 ();

  assign if_sel.in_valid  = tv[0];
  assign if_sel.in_data   = {td[0][3], td[0][2], td[0][1], td[0][0]};
  assign if_sel.sel       = tsel[0];
  assign if_sel.out_ready = tor[0];
  assign ar[0]  = if_sel.in_ready;
  assign aov[0] = if_sel.out_valid;
  assign aod[0] = if_sel.out_data;
  assign aoc[0] = if_sel.out_ch;

  assign if_rr4.in_valid  = tv[1];
  assign if_rr4.in_data   = {td[1][3], td[1][2], td[1][1], td[1][0]};
  assign if_rr4.sel       = tsel[1];
  assign if_rr4.out_ready = tor[1];
  assign ar[1]  = if_rr4.in_ready;
  assign aov[1] = if_rr4.out_valid;
  assign aod[1] = if_rr4.out_data;
  assign aoc[1] = if_rr4.out_ch;

  assign if_rr3.in_valid  = tv[2][2:0];
  assign if_rr3.in_data   = {td[2][2], td[2][1], td[2][0]};
  assign if_rr3.sel       = tsel[2];
  assign if_rr3.out_ready = tor[2];
  assign ar[2]  = {1'b0, if_rr3.in_ready};
  assign aov[2] = if_rr3.out_valid;
  assign aod[2] = if_rr3.out_data;
  assign aoc[2] = if_rr3.out_ch;

  mux_arb_n #(.WIDTH(32), .NUM_CH(4), .MODE(MODE_SEL)) u_sel (
    .clk(clk), .rst_n(rst_n), .bus_io(if_sel)
  );
  mux_arb_n #(.WIDTH(32), .NUM_CH(4), .MODE(MODE_RR)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .bus_io(if_rr4)
  );
  mux_arb_n #(.WIDTH(32), .NUM_CH(3), .MODE(MODE_RR)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .bus_io(if_rr3)
  );

  function automatic int nch(int d);
    return (d == 2) ? 3 : 4;
  endfunction

  function automatic int mode_of(int d);
    return (d == 0) ? 0 : 1;
  endfunction

  // Channel that should win this cycle, or -1.
  function automatic int exp_grant(int d);
    int n;
    int k;
    n = nch(d);
    if (mode_of(d) == 0) begin
      if (int'(tsel[d]) < n && tv[d][tsel[d]]) return int'(tsel[d]);
      return -1;
    end
    for (int i = 0; i < n; i++) begin
      k = (m_ptr[d] + i) % n;
      if (tv[d][k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int d);
    int g;
    g = exp_grant(d);
    if (!rst_n || g < 0 || (m_ov[d] && !tor[d])) return 4'b0;
    return 4'(1 << g);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_ov[d] = 1'b0; m_od[d] = '0; m_oc[d] = 0; m_ptr[d] = 0;
    end
  endtask

  task automatic model_update();
    int g [ND];
    logic [3:0] r [ND];
    for (int d = 0; d < ND; d++) begin
      g[d] = exp_grant(d);
      r[d] = exp_ready(d);
    end
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < ND; d++) begin
      if (r[d] != 4'b0) begin
        m_ov[d] = 1'b1;
        m_od[d] = td[d][g[d]];
        m_oc[d] = g[d];
        if (mode_of(d) == 1) m_ptr[d] = (g[d] + 1) % nch(d);
      end else if (tor[d]) begin
        m_ov[d] = 1'b0;
      end
    end
  endtask

  // Inputs are driven at the falling edge; sampling happens 1 unit later.
  task automatic sample();
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d in_ready", d), 32'(ar[d]), 32'(exp_ready(d)));
      check($sformatf("d%0d out_valid", d), 32'(aov[d]), 32'(m_ov[d]));
      check($sformatf("d%0d out_data", d), aod[d], m_od[d]);
      check($sformatf("d%0d out_ch", d), 32'(aoc[d]), 32'(m_oc[d]));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int d = 0; d < ND; d++) begin
      tv[d] = 4'b0; tsel[d] = 2'd0; tor[d] = 1'b1;
    end
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    sample();
    advance();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [1:0]  sel;
    logic        ordy;
    logic [3:0]  ir;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  oc;
  } vec_t;

  vec_t tbl [12];
  logic pend [ND][4];
  logic [3:0] r;

  initial begin
    tbl[0]  = '{4'b0110, 2'd2, 1'b1, 4'b0100, 1'b0, 32'h0000_0000, 2'd0};
    tbl[1]  = '{4'b0010, 2'd1, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 2'd2};
    tbl[2]  = '{4'b0010, 2'd3, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 2'd2};
    tbl[3]  = '{4'b0010, 2'd1, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 2'd2};
    tbl[4]  = '{4'b0010, 2'd1, 1'b1, 4'b0010, 1'b1, 32'hDEAD_BEEF, 2'd2};
    tbl[5]  = '{4'b1000, 2'd0, 1'b1, 4'b0000, 1'b1, 32'h2222_0001, 2'd1};
    tbl[6]  = '{4'b1000, 2'd0, 1'b0, 4'b0000, 1'b0, 32'h2222_0001, 2'd1};
    tbl[7]  = '{4'b1001, 2'd0, 1'b0, 4'b0001, 1'b0, 32'h2222_0001, 2'd1};
    tbl[8]  = '{4'b1000, 2'd3, 1'b0, 4'b0000, 1'b1, 32'h1111_0000, 2'd0};
    tbl[9]  = '{4'b1000, 2'd3, 1'b1, 4'b1000, 1'b1, 32'h1111_0000, 2'd0};
    tbl[10] = '{4'b0000, 2'd0, 1'b1, 4'b0000, 1'b1, 32'h4444_0003, 2'd3};
    tbl[11] = '{4'b0000, 2'd0, 1'b1, 4'b0000, 1'b0, 32'h4444_0003, 2'd3};

    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 4; k++) begin
        td[d][k] = 32'(k) | 32'h5000_0000; pend[d][k] = 1'b0;
      end
    end
    idle_all();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset held with every channel requesting.
    for (int d = 0; d < ND; d++) tv[d] = (d == 2) ? 4'h7 : 4'hF;
    for (int c = 0; c < 2; c++) begin
      sample();
      for (int d = 0; d < ND; d++) begin
        check($sformatf("rst c%0d d%0d in_ready", c, d), 32'(ar[d]), 32'h0);
        check($sformatf("rst c%0d d%0d out_valid", c, d), 32'(aov[d]), 32'h0);
        check($sformatf("rst c%0d d%0d out_data", c, d), aod[d], 32'h0);
      end
      advance();
    end
    rst_n = 1'b1;
    sample();
    for (int d = 0; d < ND; d++)
      check($sformatf("first grant d%0d", d), 32'(ar[d]), 32'h1);
    advance();

    // External select table.
    do_reset();
    td[0][0] = 32'h1111_0000; td[0][1] = 32'h2222_0001;
    td[0][2] = 32'hDEAD_BEEF; td[0][3] = 32'h4444_0003;
    for (int i = 0; i < 12; i++) begin
      tv[0] = tbl[i].v; tsel[0] = tbl[i].sel; tor[0] = tbl[i].ordy;
      sample();
      check($sformatf("tbl%0d in_ready", i), 32'(ar[0]), 32'(tbl[i].ir));
      check($sformatf("tbl%0d out_valid", i), 32'(aov[0]), 32'(tbl[i].ov));
      check($sformatf("tbl%0d out_data", i), aod[0], tbl[i].od);
      check($sformatf("tbl%0d out_ch", i), 32'(aoc[0]), 32'(tbl[i].oc));
      advance();
    end
    idle_all();

    // Round-robin fairness, all four requesting, data = channel index.
    for (int k = 0; k < 4; k++) td[1][k] = 32'(k);
    tv[1] = 4'hF;
    sample();
    check("rr4 first in_ready", 32'(ar[1]), 32'h1);
    advance();
    for (int i = 0; i < 6; i++) begin
      sample();
      check($sformatf("rr4 seq%0d out_ch", i), 32'(aoc[1]), 32'(i % 4));
      check($sformatf("rr4 seq%0d out_data", i), aod[1], 32'(i % 4));
      check($sformatf("rr4 seq%0d out_valid", i), 32'(aov[1]), 32'h1);
      advance();
    end
    idle_all();
    sample();
    advance();

    // Three-channel skip and wrap: ptr 0 -> 2 -> 1 -> 0.
    do_reset();
    tv[2] = 4'b0010; sample(); check("rr3 grant1", 32'(ar[2]), 32'h2); advance();
    tv[2] = 4'b0001; sample(); check("rr3 skip to 0", 32'(ar[2]), 32'h1); advance();
    tv[2] = 4'b0100; sample(); check("rr3 grant2", 32'(ar[2]), 32'h4);
    check("rr3 out_ch after skip", 32'(aoc[2]), 32'h0); advance();
    tv[2] = 4'b0111; sample(); check("rr3 wrap to 0", 32'(ar[2]), 32'h1);
    check("rr3 out_ch 2", 32'(aoc[2]), 32'h2); advance();
    idle_all();

    // Reset pulse while holding a word.
    do_reset();
    td[0][2] = 32'hDEAD_BEEF; tv[0] = 4'b0100; tsel[0] = 2'd2; tor[0] = 1'b1;
    sample(); advance();
    tv[0] = 4'b0100; tor[0] = 1'b0;
    sample();
    check("hold out_valid", 32'(aov[0]), 32'h1);
    check("hold out_data", aod[0], 32'hDEAD_BEEF);
    check("hold in_ready", 32'(ar[0]), 32'h0);
    advance();
    rst_n = 1'b0; tv[0] = 4'b0;
    sample(); check("mid rst in_ready", 32'(ar[0]), 32'h0); advance();
    rst_n = 1'b1; tor[0] = 1'b1;
    sample();
    check("post rst out_valid", 32'(aov[0]), 32'h0);
    check("post rst out_data", aod[0], 32'h0);
    advance();
    sample(); check("post rst out_valid 2", 32'(aov[0]), 32'h0); advance();

    // Randomised traffic with producers holding requests until accepted.
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(49, 0) != 0);
      for (int d = 0; d < ND; d++) begin
        tv[d] = 4'b0;
        for (int k = 0; k < nch(d); k++) begin
          if (!pend[d][k] && $urandom_range(1, 0) == 1) begin
            pend[d][k] = 1'b1;
            td[d][k]   = $urandom();
          end
          tv[d][k] = pend[d][k];
        end
        tsel[d] = 2'($urandom_range(3, 0));
        tor[d]  = ($urandom_range(3, 0) != 0);
      end
      sample();
      for (int d = 0; d < ND; d++) begin
        r = exp_ready(d);
        for (int k = 0; k < 4; k++) if (r[k]) pend[d][k] = 1'b0;
      end
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Replaces the fixed combinational 4:1 datapath mux wherever several producers share one consumer, e.g. writeback sources, bus masters or debug taps.
- Two selection modes, fixed at elaboration:
  - externally steered (sel), or
  - internal round-robin arbitration.
- One-entry output register; full throughput of one transfer per cycle.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_CH, 4, number of input channels, 2..16.
- SEL_W, $clog2(NUM_CH), width of sel and out_ch (derived; do not override).
- MODE, 0, 0 = SEL (external select), 1 = RR (round-robin).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  NUM_CH  per-channel request.
- in_data  in  NUM_CH*WIDTH  flattened; channel k occupies bits [k*WIDTH +: WIDTH].
- in_ready  out  NUM_CH  one-hot-or-zero accept strobe.
- sel  in  SEL_W  channel select; used only when MODE=0.
- out_valid  out  1  output register holds data.
- out_data  out  WIDTH  registered selected data.
- out_ch  out  SEL_W  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts out_data.

Behaviour:
- Reset: rst_n sampled low at a clk edge clears the registers.
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - While rst_n=0, in_ready is forced to 0.
  - Reset mid-transfer discards held data. No in_ready is raised in the reset cycle.
- load_en = !out_valid | out_ready. The output register can accept new data when empty or when it is being drained in the same cycle.
- Grant g, combinational:
  - MODE=0: g=sel. There is no grant when sel>=NUM_CH or in_valid[sel]=0. Other channels are ignored even if valid.
  - MODE=1: g is the first k with in_valid[k]=1, searching k=rr_ptr, rr_ptr+1, … modulo NUM_CH. There is no grant if in_valid is all-zero.
- in_ready[k] = rst_n & load_en & grant_valid & (k==g). At most one bit is set. in_ready never depends on in_valid[k] of the same channel through a combinational loop beyond the grant logic.
- Transfer on channel k when in_valid[k]&in_ready[k]. At the next edge: out_data=in_data[k], out_ch=k, out_valid=1.
- Latency: 1 cycle from input transfer to out_valid.
- Hold: while out_valid=1 and out_ready=0, out_data/out_ch/out_valid are stable and in_ready=0.
- Drain with no new grant: out_valid&out_ready and no grant, so out_valid goes 0 at the next edge; out_data keeps its last value.
- Simultaneous drain and load: out_valid stays 1 and out_data is replaced. No bubble.
- RR pointer:
  - After a transfer from channel g, rr_ptr = (g==NUM_CH-1) ? 0 : g+1.
  - rr_ptr is unchanged when there is no transfer.
  - The pointer wraps correctly for non-power-of-2 NUM_CH.
- In MODE=0, rr_ptr is held at 0.
- The sel value is only meaningful in the cycle it is sampled. A sel change while out is stalled has no effect on held data.
- Producers must hold in_valid/in_data stable until accepted. The block does not check this.

Decomposition:
- Package mux_arb_pkg:
  - mode constants MODE_SEL=0, MODE_RR=1;
  - a function for the next-pointer wrap.
- One sub-module, rr_arbiter:
  - parameter NUM_CH;
  - inputs req[NUM_CH], ptr;
  - outputs grant_valid, grant_idx.
  - Purely combinational.
  - Instantiated only under MODE=1 via generate.
- The output register, pointer and in_ready gating stay in mux_arb_n.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with in_valid=4'hF, out_ready=1 -> out_valid=0, out_data=0, in_ready=0 throughout; the first grant appears in the cycle rst_n=1.
2. MODE=0, sel=2, in_valid=4'b0110, in_data[2]=32'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100 that cycle; the next cycle out_valid=1, out_data=32'hDEADBEEF, out_ch=2.
3. MODE=0 stall: out_ready=0 for 3 cycles after a load -> out_data/out_ch stable, in_ready=0; on out_ready=1 with a pending request, back-to-back reload with no bubble.
4. MODE=1 fairness: in_valid=4'hF held, out_ready=1, data=channel index -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
5. MODE=1 skip/wrap, NUM_CH=3: rr_ptr=2, in_valid=3'b001 -> grant 0, rr_ptr becomes 1; in_valid=3'b100 -> grant 2, rr_ptr wraps to 0.
6. Reset mid-hold: out_valid=1, out_ready=0, rst_n pulsed low one cycle -> out_valid=0 the next cycle; the held word is never presented after reset.
